// File: rtl/muldiv_unit.sv
// Multicycle multiply/divide unit owning the Hi/Lo register pair.
// Shift-add multiply and restoring divide, one bit per cycle, with sign fix-up.
module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic             op_div,
   input  logic             op_signed,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   input  logic             hi_wr,
   input  logic             lo_wr,
   input  logic [WIDTH-1:0] wr_data,
   output logic             busy,
   output logic             done,
   output logic             divby0,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t               state_r, nextState_s;
   logic [2*WIDTH-1:0]   acc_r, stepAcc_s, prod_s;
   logic [WIDTH-1:0]     mcand_r, fixHi_s, fixLo_s;
   logic [WIDTH-1:0]     aMag_s, bMag_s;
   logic [WIDTH:0]       partial_s, trial_s, sum_s;
   logic [CW-1:0]        cnt_r;
   logic                 isDiv_r, negQ_r, negR_r;
   logic                 aNeg_s, bNeg_s, zeroDiv_s;

   function automatic logic [WIDTH-1:0] negW(input logic [WIDTH-1:0] v);
      return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
   endfunction

   assign aNeg_s    = op_signed & src_a[WIDTH-1];
   assign bNeg_s    = op_signed & src_b[WIDTH-1];
   assign aMag_s    = aNeg_s ? negW(src_a) : src_a;
   assign bMag_s    = bNeg_s ? negW(src_b) : src_b;
   assign zeroDiv_s = op_div & (src_b == {WIDTH{1'b0}});

   // FSM state register
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= nextState_s;
      end
   end

   // FSM next-state logic
   always_comb begin
      nextState_s = state_r;
      case (state_r)
         IDLE: begin
            if (start) begin
               nextState_s = zeroDiv_s ? DONE : CALC;
            end else begin
               nextState_s = IDLE;
            end
         end
         CALC: begin
            if (cnt_r == {CW{1'b0}}) begin
               nextState_s = FIX;
            end else begin
               nextState_s = CALC;
            end
         end
         FIX:     nextState_s = DONE;
         DONE:    nextState_s = IDLE;
         default: nextState_s = IDLE;
      endcase
   end

   // One iteration of shift-add multiply or restoring divide, plus sign fix-up
   always_comb begin
      partial_s = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-1]};
      trial_s   = partial_s - {1'b0, mcand_r};
      sum_s     = {1'b0, acc_r[2*WIDTH-1:WIDTH]};
      stepAcc_s = acc_r;
      if (isDiv_r) begin
         // Borrow out of the trial subtraction means the divisor did not fit
         if (!trial_s[WIDTH]) begin
            stepAcc_s = {trial_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
         end else begin
            stepAcc_s = {partial_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
         end
      end else begin
         if (acc_r[0]) begin
            sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + {1'b0, mcand_r};
         end else begin
            sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]};
         end
         stepAcc_s = {sum_s, acc_r[WIDTH-1:1]};
      end

      prod_s = negQ_r ? (~acc_r + {{(2*WIDTH-1){1'b0}}, 1'b1}) : acc_r;
      if (isDiv_r) begin
         fixLo_s = negQ_r ? negW(acc_r[WIDTH-1:0]) : acc_r[WIDTH-1:0];
         fixHi_s = negR_r ? negW(acc_r[2*WIDTH-1:WIDTH]) : acc_r[2*WIDTH-1:WIDTH];
      end else begin
         fixLo_s = prod_s[WIDTH-1:0];
         fixHi_s = prod_s[2*WIDTH-1:WIDTH];
      end
   end

   // Datapath, Hi/Lo registers and registered handshake outputs
   always_ff @(posedge clock) begin
      if (reset) begin
         acc_r   <= {(2*WIDTH){1'b0}};
         mcand_r <= {WIDTH{1'b0}};
         cnt_r   <= {CW{1'b0}};
         isDiv_r <= 1'b0;
         negQ_r  <= 1'b0;
         negR_r  <= 1'b0;
         hi      <= {WIDTH{1'b0}};
         lo      <= {WIDTH{1'b0}};
         busy    <= 1'b0;
         done    <= 1'b0;
         divby0  <= 1'b0;
      end else begin
         busy   <= (nextState_s != IDLE);
         done   <= (nextState_s == DONE);
         divby0 <= (state_r == IDLE) & start & zeroDiv_s;
         case (state_r)
            IDLE: begin
               if (hi_wr) hi <= wr_data;
               if (lo_wr) lo <= wr_data;
               if (start && !zeroDiv_s) begin
                  acc_r   <= {{WIDTH{1'b0}}, (op_div ? aMag_s : bMag_s)};
                  mcand_r <= op_div ? bMag_s : aMag_s;
                  cnt_r   <= CW'(WIDTH - 1);
                  isDiv_r <= op_div;
                  negQ_r  <= aNeg_s ^ bNeg_s;
                  negR_r  <= aNeg_s;
               end
            end
            CALC: begin
               acc_r <= stepAcc_s;
               cnt_r <= cnt_r - {{(CW-1){1'b0}}, 1'b1};
            end
            FIX: begin
               hi <= fixHi_s;
               lo <= fixLo_s;
            end
            DONE: begin
               acc_r <= acc_r;
            end
            default: begin
               acc_r <= acc_r;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: cycle-level reference model checked every
// cycle, plus directed operations with hand-computed results and latencies.
module tb_muldiv_unit;
   localparam int W = 32;

   logic clock = 1'b0, reset = 1'b1, start = 1'b0, op_div = 1'b0, op_signed = 1'b0;
   logic hi_wr = 1'b0, lo_wr = 1'b0;
   logic [W-1:0] src_a = '0, src_b = '0, wr_data = '0;
   logic busy, done, divby0;
   logic [W-1:0] hi, lo;

   int errors = 0;
   int checks = 0;
   bit checkEn = 1'b0;

   always #5 clock = ~clock;

   muldiv_unit #(.WIDTH(W)) dut (
      .clock(clock), .reset(reset), .start(start), .op_div(op_div),
      .op_signed(op_signed), .src_a(src_a), .src_b(src_b), .hi_wr(hi_wr),
      .lo_wr(lo_wr), .wr_data(wr_data), .busy(busy), .done(done),
      .divby0(divby0), .hi(hi), .lo(lo)
   );

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference arithmetic: {hi, lo} for an operation, using plain 64-bit maths
   function automatic logic [63:0] refResult(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic d, input logic s);
      logic [63:0] ea, eb, q, r;
      longint sa, sb;
      ea = s ? {{32{a[31]}}, a} : {32'h0, a};
      eb = s ? {{32{b[31]}}, b} : {32'h0, b};
      if (!d) return ea * eb;
      if (s) begin
         sa = $signed(ea);
         sb = $signed(eb);
         q  = sa / sb;
         r  = sa % sb;
      end else begin
         q = ea / eb;
         r = ea % eb;
      end
      return {r[31:0], q[31:0]};
   endfunction

   // Cycle model: an operation occupies W+2 busy cycles (done in the last), div-by-zero one
   logic mBusy, mDone, mDiv0;
   logic [W-1:0] mHi, mLo, pHi, pLo;
   int mLeft;

   always @(posedge clock) begin
      if (reset) begin
         mBusy <= 1'b0; mDone <= 1'b0; mDiv0 <= 1'b0;
         mHi <= '0; mLo <= '0; mLeft <= 0;
      end else if (!mBusy) begin
         mDone <= 1'b0; mDiv0 <= 1'b0;
         if (hi_wr) mHi <= wr_data;
         if (lo_wr) mLo <= wr_data;
         if (start) begin
            mBusy <= 1'b1;
            if (op_div && src_b == '0) begin
               mDone <= 1'b1; mDiv0 <= 1'b1; mLeft <= 0;
            end else begin
               {pHi, pLo} <= refResult(src_a, src_b, op_div, op_signed);
               mLeft <= W + 1;
            end
         end
      end else if (mLeft == 0) begin
         mBusy <= 1'b0; mDone <= 1'b0; mDiv0 <= 1'b0;
      end else begin
         mLeft <= mLeft - 1;
         if (mLeft == 1) begin
            mHi <= pHi; mLo <= pLo; mDone <= 1'b1;
         end
      end
   end

   // Compare DUT against the model every cycle, mid-cycle
   always @(negedge clock) begin
      if (checkEn) begin
         check("status", {61'h0, busy, done, divby0}, {61'h0, mBusy, mDone, mDiv0});
         check("hilo", {hi, lo}, {mHi, mLo});
      end
   end

   task automatic tick();
      @(posedge clock);
      #2;
   endtask

   task automatic runOp(input logic [W-1:0] a, input logic [W-1:0] b, input logic d,
                        input logic s, input logic [W-1:0] eh, input logic [W-1:0] el,
                        input logic ediv0, input int ecyc, input bit disturb, input string nm);
      int cyc;
      bit seen;
      src_a = a; src_b = b; op_div = d; op_signed = s; start = 1'b1;
      tick();
      start = 1'b0;
      cyc = 1;
      seen = 1'b0;
      while (!seen && cyc < 200) begin
         @(negedge clock);
         if (done) begin
            seen = 1'b1;
            check({nm, "_cycle"}, 64'(cyc), 64'(ecyc));
            check({nm, "_div0"}, {63'h0, divby0}, {63'h0, ediv0});
            check({nm, "_res"}, {hi, lo}, {eh, el});
         end else begin
            tick();
            cyc++;
            start   = disturb && (cyc == 10 || cyc == W + 2);
            hi_wr   = disturb && (cyc == 5);
            wr_data = 32'hDEAD_BEEF;
            if (disturb && cyc == 10) src_a = 32'h0000_0001;
         end
      end
      if (!seen) check({nm, "_timeout"}, 64'd0, 64'd1);
      tick();
      start = 1'b0;
      hi_wr = 1'b0;
   endtask

   task automatic expectNoDone(input int n, input string nm);
      int cnt;
      cnt = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clock);
         if (done) cnt++;
      end
      check(nm, 64'(cnt), 64'd0);
      tick();
   endtask

   initial begin
      tick();
      checkEn = 1'b1;
      @(negedge clock);
      check("reset_state", {59'h0, busy, done, divby0, |hi, |lo}, 64'h0);
      tick();
      reset = 1'b0;

      runOp(32'd7, 32'hFFFF_FFFD, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 34, 1'b0, "mult");
      runOp(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 34, 1'b0, "multu");
      runOp(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1, 32'h4000_0000, 32'h0, 1'b0, 34, 1'b0, "mult_min");
      runOp(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 34, 1'b0, "div");
      runOp(32'd7, 32'hFFFF_FFFE, 1'b1, 1'b1, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, 34, 1'b0, "div_negb");
      runOp(32'h8000_0000, 32'd3, 1'b1, 1'b0, 32'h0000_0002, 32'h2AAA_AAAA, 1'b0, 34, 1'b0, "divu");
      runOp(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'h0, 32'h8000_0000, 1'b0, 34, 1'b0, "min_neg1");

      hi_wr = 1'b1; lo_wr = 1'b1; wr_data = 32'h1234_5678;
      tick();
      hi_wr = 1'b0; lo_wr = 1'b0;
      runOp(32'd5, 32'd0, 1'b1, 1'b1, 32'h1234_5678, 32'h1234_5678, 1'b1, 1, 1'b0, "div0");

      // Write alongside an accepted start: write lands, result overwrites later
      lo_wr = 1'b1; wr_data = 32'hCAFE_0000;
      runOp(32'd6, 32'd7, 1'b0, 1'b0, 32'h0, 32'd42, 1'b0, 34, 1'b0, "wr_start");
      lo_wr = 1'b0;

      // Start during busy and in the done cycle, hi_wr during busy: all dropped
      runOp(32'd7, 32'hFFFF_FFFD, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 34, 1'b1, "busy_start");
      expectNoDone(40, "extra_done");

      // Reset in cycle 20 of a multiply aborts it
      src_a = 32'd9; src_b = 32'd9; op_div = 1'b0; op_signed = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 1; c < 20; c++) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      @(negedge clock);
      check("abort_state", {59'h0, busy, done, divby0, |hi, |lo}, 64'h0);
      tick();
      expectNoDone(40, "abort_done");

      runOp(32'd100, 32'd7, 1'b1, 1'b0, 32'd2, 32'd14, 1'b0, 34, 1'b0, "after_reset");

      checkEn = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
